// File: rtl/uart_tx_driver.sv
// uart_tx_driver: 8N1 serial transmitter fed by a small byte FIFO.
// Fixed clock count per bit; registered line output, idle high.
module uart_tx_driver #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_AW      = 3
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic [7:0]         wdata,
  input  logic               wvalid,
  output logic               wready,
  output logic               tx,
  output logic               busy,
  output logic [FIFO_AW:0]   level
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wptr;
  logic [FIFO_AW:0] rptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             bit_end;

  // Pointer MSBs differ only when the write side has lapped the read side.
  assign empty = (wptr == rptr);
  assign full  =
    (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
    (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);

  // A pop this cycle does not free a slot for this cycle's write.
  assign push    = wvalid && !full;
  assign bit_end = (cnt == CNT_LAST);

  assign wready = !full;
  assign level  = wptr - rptr;
  assign busy   = (state != IDLE) || !empty;

  // Pop the head when idle, or at the very end of a stop bit.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = !empty;
      STOP:    pop = bit_end && !empty;
      default: pop = 1'b0;
    endcase
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge HCLK) begin
    if (push) begin
      mem[wptr[FIFO_AW-1:0]] <= wdata;
    end
  end

  // Read and write pointers, wrapping modulo twice the depth.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

  // Frame sequencer: start bit, eight data bits LSB first, stop bit.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx  <= 1'b1;
          cnt <= '0;
          if (!empty) begin
            shift <= mem[rptr[FIFO_AW-1:0]];
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[bit_idx + 3'd1];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (!empty) begin
              shift <= mem[rptr[FIFO_AW-1:0]];
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
